rr_arbiter_8: RTL and testbench

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

---
 rtl/rr_arbiter_8_pkg.sv | 14 +
 rtl/decoder_3to8.sv | 15 +
 rtl/rr_arbiter_8.sv | 90 +++++++++
 tb/tb_rr_arbiter_8.sv | 127 ++++++++++++
 4 files changed

// File: rtl/rr_arbiter_8_pkg.sv
// rr_arbiter_8_pkg: shared state encoding, requester count and index type for the arbiter
package rr_arbiter_8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/decoder_3to8.sv
// decoder_3to8: enable-gated binary to one-hot decoder
module decoder_3to8
    import rr_arbiter_8_pkg::*;
(
    input  logic [IDX_W-1:0] sel_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] dec_o
);

    // One-hot of sel_i, all zero while disabled
    always_comb begin
        dec_o = en_i ? (N_REQ'(1) << sel_i) : '0;
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: 8-way round-robin arbiter with registered grant, release and hold-time limit
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    state_e     state_q;
    idx_t       idx_q;
    idx_t       last_q;
    idx_t       pick;
    logic [7:0] hold_q;
    logic       valid_q;
    logic       timeout_q;
    logic       release_c;
    logic       limit_c;

    // Priority search: first set request strictly after the last owner, wrapping; the
    // descending loop lets the nearest candidate overwrite farther ones
    always_comb begin
        pick = last_q;
        for (int i = N_REQ; i >= 1; i--) begin
            if (req[last_q + idx_t'(i)]) pick = last_q + idx_t'(i);
        end
    end

    assign release_c = done || !req[idx_q];
    assign limit_c   = (hold_q == 8'(MAX_HOLD - 1));

    // Arbitration FSM with registered grant, hold counter and timeout pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= idx_t'(N_REQ - 1);
            last_q    <= idx_t'(N_REQ - 1);
            hold_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    timeout_q <= 1'b0;
                    if (|req) begin
                        state_q <= GRANT;
                        idx_q   <= pick;
                        last_q  <= pick;
                        hold_q  <= '0;
                        valid_q <= 1'b1;
                    end
                end
                GRANT: begin
                    if (release_c) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end else if (limit_c) begin
                        state_q   <= IDLE;
                        valid_q   <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    decoder_3to8 u_dec (
        .sel_i (idx_q),
        .en_i  (valid_q),
        .dec_o (gnt)
    );

    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed vector table plus hand sequences for the round-robin arbiter
module tb_rr_arbiter_8;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vq[$];

    rr_arbiter_8 #(.MAX_HOLD(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic add(input logic [7:0] r, input logic d, input logic [7:0] g,
                       input logic [2:0] i, input logic v, input logic t);
        vq.push_back('{req: r, done: d, gnt: g, idx: i, valid: v, to: t});
    endtask

    task automatic check(input string name, input logic [7:0] g, input logic [2:0] i,
                         input logic v, input logic t);
        n_vec++;
        if ({gnt, gnt_idx, gnt_valid, timeout} !== {g, i, v, t}) begin
            n_err++;
            $display("FAIL %s: got gnt=%h idx=%0d valid=%b to=%b, want gnt=%h idx=%0d valid=%b to=%b",
                     name, gnt, gnt_idx, gnt_valid, timeout, g, i, v, t);
        end
    endtask

    initial begin
        // req=81 held: requester 0 wins first after reset, then released by done
        add(8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
        add(8'h81, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        add(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        add(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        // all requesting with done pulsed: rotation 1..7,0 with one idle gap each
        for (int k = 1; k <= 8; k++) begin
            add(8'hFF, 1'b0, 8'h01 << (k % 8), 3'(k % 8), 1'b1, 1'b0);
            add(8'hFF, 1'b1, 8'h00, 3'(k % 8), 1'b0, 1'b0);
        end
        // single persistent requester 2: 15 grant cycles, timeout pulse, re-grant
        for (int k = 0; k < 15; k++) add(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
        add(8'h04, 1'b0, 8'h00, 3'd2, 1'b0, 1'b1);
        add(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
        add(8'h04, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0);
        // owner 3 drops its request while 5 waits
        add(8'h28, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
        add(8'h20, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0);
        add(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
        add(8'h20, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0);
        // done on the same edge as the hold limit: plain release, no timeout
        for (int k = 0; k < 15; k++) add(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
        add(8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        add(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        // done high in IDLE does not block a new grant
        add(8'h02, 1'b1, 8'h02, 3'd1, 1'b1, 1'b0);
        add(8'h02, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0);
        // requester 4 takes the grant for the async reset sequence
        add(8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);

        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        #12;
        check("reset_state", 8'h00, 3'd7, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_no_req", 8'h00, 3'd7, 1'b0, 1'b0);

        foreach (vq[n]) begin
            req  = vq[n].req;
            done = vq[n].done;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", n), vq[n].gnt, vq[n].idx, vq[n].valid, vq[n].to);
        end

        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid_grant", 8'h00, 3'd7, 1'b0, 1'b0);
        req = 8'h03;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_prio0", 8'h01, 3'd0, 1'b1, 1'b0);
        req = 8'h03;
        done = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_release", 8'h00, 3'd0, 1'b0, 1'b0);
        done = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_next1", 8'h02, 3'd1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
